// File: rtl/pkt_fork_pkg.sv
// -----------------------------------------------------------------------------
// pkt_fork_pkg
//   Shared definitions for the packet fork (reader side of the merge output
//   FIFO): word field positions and the routing FSM encoding.
// -----------------------------------------------------------------------------
package pkt_fork_pkg;

    // Packet word layout: [152] eop, [151] dst, [150:128] meta, [127:0] payload
    localparam int EOP_BIT     = 152;
    localparam int DST_BIT     = 151;
    localparam int PAYLOAD_MSB = 127;

    // Routing FSM: IDLE means the head word is the first word of a packet
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } fork_state_e;

endpackage : pkt_fork_pkg

// File: rtl/pkt_fork_buf.sv
// -----------------------------------------------------------------------------
// pkt_fork_buf
//   Two-entry circular holding buffer between the upstream FIFO read port and
//   the egress steering logic.
//
//   Ports:
//     clk        clock
//     rst        synchronous reset, active-low (clears pointers and occupancy)
//     push       write push_data at the tail this cycle
//     push_data  word to write
//     pop        remove the head word this cycle
//     head       current head word (meaningful only while cnt != 0)
//     cnt        occupancy, 0..2
//
//   The caller guarantees no push while full and no pop while empty.
// -----------------------------------------------------------------------------
module pkt_fork_buf
    import pkt_fork_pkg::*;
#(
    parameter int DW = 153
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    cnt
);

    logic [DW-1:0] mem_p0 [2];
    logic          wr_ptr;
    logic          rd_ptr;

    // Control: pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            // Simultaneous push and pop leaves the occupancy unchanged
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Data storage carries no reset; stale entries are never presented
    // because the consumer qualifies head with cnt.
    always_ff @(posedge clk) begin
        if (push) mem_p0[wr_ptr] <= push_data;
    end

    assign head = mem_p0[rd_ptr];

endmodule : pkt_fork_buf

// File: rtl/pkt_fork.sv
// -----------------------------------------------------------------------------
// pkt_fork
//   Drains packet words from a single-clock FIFO with a 1-cycle registered
//   read and steers each whole packet to one of two valid/ready egress ports,
//   selected by the dst bit of the packet's first word. Packets leave in
//   arrival order (a packet blocked on one port holds back everything behind
//   it). Per-port packet counters count accepted eop words.
//
//   Ports:
//     clk, rst              clock; synchronous reset, active-low
//     in_data               upstream FIFO read data, valid one cycle after in_re
//     in_empty              upstream FIFO empty
//     in_re                 upstream read enable (never while in_empty)
//     out0_data/valid/ready port-0 egress handshake
//     out1_data/valid/ready port-1 egress handshake
//     pkt_cnt0, pkt_cnt1    packets completed per port (wrap modulo 2^CW)
//     busy                  mid-packet, or any word buffered or in flight
// -----------------------------------------------------------------------------
module pkt_fork
    import pkt_fork_pkg::*;
#(
    parameter int DW = 153,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_empty,
    output logic          in_re,
    output logic [DW-1:0] out0_data,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1,
    output logic          busy
);

    fork_state_e   state;
    fork_state_e   state_nxt;
    logic          rd_pend;
    logic          cur_dst;
    logic          port_sel;
    logic [DW-1:0] head;
    logic [1:0]    buf_cnt;
    logic          xfer0;
    logic          xfer1;
    logic          drain;
    logic          head_eop;
    logic [2:0]    occ_after;

    pkt_fork_buf #(
        .DW (DW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (in_data),
        .pop       (drain),
        .head      (head),
        .cnt       (buf_cnt)
    );

    assign head_eop = head[EOP_BIT];
    assign xfer0    = out0_valid && out0_ready;
    assign xfer1    = out1_valid && out1_ready;
    assign drain    = xfer0 || xfer1;

    // Words already held plus the one landing next edge, minus the one
    // leaving this cycle. Issuing only while this is below 2 means the
    // buffer can never overflow, yet allows one read per cycle when the
    // consumer drains every cycle. drain implies buf_cnt >= 1, so no
    // underflow.
    assign occ_after = {1'b0, buf_cnt} + {2'b00, rd_pend} - {2'b00, drain};
    assign in_re     = rst && !in_empty && (occ_after < 3'd2);

    // Read-latency stage: in_re registered marks in_data as valid
    always_ff @(posedge clk) begin
        if (!rst) rd_pend <= 1'b0;
        else      rd_pend <= in_re;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drain && !head_eop) state_nxt = IN_PKT;
            IN_PKT:  if (drain &&  head_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Destination of the packet in progress, captured as its first word leaves
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_dst <= 1'b0;
        end else if (state == IDLE && drain) begin
            cur_dst <= head[DST_BIT];
        end
    end

    // FSM outputs: built only from registered state, so ready never feeds
    // back into valid or data.
    always_comb begin
        port_sel   = (state == IDLE) ? head[DST_BIT] : cur_dst;
        out0_valid = (buf_cnt != 2'd0) && !port_sel;
        out1_valid = (buf_cnt != 2'd0) &&  port_sel;
    end

    assign out0_data = head;
    assign out1_data = head;

    // Per-port completed-packet counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (xfer0 && head_eop) pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (xfer1 && head_eop) pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
    end

    assign busy = (state == IN_PKT) || (buf_cnt != 2'd0) || rd_pend;

endmodule : pkt_fork

// File: tb/tb_pkt_fork.sv
// -----------------------------------------------------------------------------
// tb_pkt_fork
//   Bench for pkt_fork. An upstream FIFO with one-cycle read latency is
//   modelled with a queue; the reference is the ordered list of words each
//   packet must deliver, tagged with the port given by its first word.
// -----------------------------------------------------------------------------
module tb_pkt_fork;
    import pkt_fork_pkg::*;

    localparam int DW = 153;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_empty = 1'b1;
    logic          in_re;
    logic [DW-1:0] out0_data;
    logic          out0_valid;
    logic          out0_ready = 1'b0;
    logic [DW-1:0] out1_data;
    logic          out1_valid;
    logic          out1_ready = 1'b0;
    logic [CW-1:0] pkt_cnt0;
    logic [CW-1:0] pkt_cnt1;
    logic          busy;

    pkt_fork #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_empty   (in_empty),
        .in_re      (in_re),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] fifo_q[$];   // words still in the upstream FIFO
    logic [DW-1:0] exp_w[$];    // words still to be delivered, in order
    bit            exp_p[$];    // port each of those words must appear on
    int            buffered;    // words inside the fork
    int            pend;        // read issued last cycle, landing next edge
    int            m_cnt0, m_cnt1;
    int            ready_mode;
    int            starve_pct;
    int            step_idx;
    int            cyc;
    int            first_x, last_x;

    function automatic logic [DW-1:0] mk_word(bit eop, bit dst, logic [127:0] pl);
        logic [22:0] meta;
        meta = 23'($urandom);
        return {eop, dst, meta, pl};
    endfunction

    task automatic add_word(input logic [DW-1:0] w, input bit port);
        fifo_q.push_back(w);
        exp_w.push_back(w);
        exp_p.push_back(port);
    endtask

    // scramble: later words carry the opposite dst, which must be ignored
    task automatic push_pkt(input int len, input bit dst, input bit scramble);
        logic [127:0] pl;
        bit d;
        for (int i = 0; i < len; i++) begin
            pl = {$urandom, $urandom, $urandom, $urandom};
            if (i == 0)        d = dst;
            else if (scramble) d = ~dst;
            else               d = 1'($urandom);
            add_word(mk_word(i == len - 1, d, pl), dst);
        end
    endtask

    task automatic step();
        bit r0, r1, x0, x1, took;
        logic [DW-1:0] w;
        case (ready_mode)
            0:       begin r0 = 1'b1; r1 = 1'b1; end
            1:       begin r0 = (step_idx % 3 == 0) || (step_idx % 3 == 3); r1 = 1'b1; end
            2:       begin r0 = ($urandom_range(0, 9) < 7); r1 = ($urandom_range(0, 9) < 7); end
            3:       begin r0 = 1'b1; r1 = (step_idx >= 10); end
            default: begin r0 = 1'b0; r1 = 1'b0; end
        endcase
        out0_ready = r0;
        out1_ready = r1;
        in_empty   = (fifo_q.size() == 0) || ($urandom_range(0, 99) < starve_pct);
        @(negedge clk);
        x0 = out0_valid && r0;
        x1 = out1_valid && r1;
        check("in_re_rule", in_re, !in_empty && (buffered + pend - int'(x0 | x1) < 2));
        check("occ_max", (buffered + pend) <= 2, 1);
        check("any_valid", out0_valid | out1_valid, buffered > 0);
        check("pkt_cnt0", pkt_cnt0, CW'(m_cnt0));
        check("pkt_cnt1", pkt_cnt1, CW'(m_cnt1));
        if ((out0_valid || out1_valid) && exp_w.size() > 0) begin
            check("both_valid", out0_valid & out1_valid, 0);
            check("port", out1_valid, exp_p[0]);
            check("data", out1_valid ? out1_data : out0_data, exp_w[0]);
        end
        if ((x0 || x1) && exp_w.size() > 0) begin
            if (exp_w[0][EOP_BIT]) begin
                if (x1) m_cnt1++;
                else    m_cnt0++;
            end
            void'(exp_w.pop_front());
            void'(exp_p.pop_front());
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
        end
        took = in_re;
        w = '0;
        if (took) begin
            if (fifo_q.size() > 0) w = fifo_q.pop_front();
            else check("read_from_empty", 1, 0);
        end
        @(posedge clk);
        #1;
        if (took) in_data = w;
        buffered = buffered + pend - int'(x0 | x1);
        pend     = int'(took);
        step_idx++;
        cyc++;
    endtask

    task automatic drain_all(input int max_steps);
        int n;
        n = 0;
        while (exp_w.size() > 0 && n < max_steps) begin
            step();
            n++;
        end
        check("drain_timeout", exp_w.size(), 0);
        check("busy_idle", busy, 0);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        in_empty = 1'b1;
        fifo_q.delete();
        exp_w.delete();
        exp_p.delete();
        @(posedge clk);
        #1;
        check("rst_valid0", out0_valid, 0);
        check("rst_valid1", out1_valid, 0);
        check("rst_in_re", in_re, 0);
        check("rst_cnt0", pkt_cnt0, 0);
        check("rst_cnt1", pkt_cnt1, 0);
        check("rst_busy", busy, 0);
        rst      = 1'b1;
        buffered = 0;
        pend     = 0;
        m_cnt0   = 0;
        m_cnt1   = 0;
        step_idx = 0;
    endtask

    initial begin
        ready_mode = 0;
        starve_pct = 0;
        cyc        = 0;
        first_x    = -1;
        last_x     = -1;
        do_reset();

        // Single-word packet to port 1
        add_word(mk_word(1'b1, 1'b1, 128'hA5), 1'b1);
        drain_all(20);
        check("t1_cnt1", pkt_cnt1, 1);
        check("t1_cnt0", pkt_cnt0, 0);

        // 4-word packet to port 0, later words carry dst=1
        push_pkt(4, 1'b0, 1'b1);
        drain_all(40);
        check("t2_cnt0", pkt_cnt0, 1);

        // Same shape with port-0 ready toggling 1,0,0
        ready_mode = 1;
        step_idx   = 0;
        push_pkt(4, 1'b0, 1'b1);
        drain_all(60);
        check("t3_cnt0", pkt_cnt0, 2);

        // Back-to-back 2-word packets, one word per cycle
        do_reset();
        ready_mode = 0;
        first_x    = -1;
        push_pkt(2, 1'b1, 1'b0);
        push_pkt(2, 1'b0, 1'b0);
        drain_all(40);
        check("t4_rate", last_x - first_x, 3);
        check("t4_cnt0", pkt_cnt0, 1);
        check("t4_cnt1", pkt_cnt1, 1);

        // Head-of-line blocking: port 1 stalled for 10 cycles
        ready_mode = 3;
        step_idx   = 0;
        push_pkt(3, 1'b1, 1'b0);
        push_pkt(2, 1'b0, 1'b0);
        drain_all(80);
        check("t5_cnt0", pkt_cnt0, 2);
        check("t5_cnt1", pkt_cnt1, 2);

        // Reset mid-packet with a read in flight
        ready_mode = 4;
        push_pkt(4, 1'b1, 1'b0);
        step();
        step();
        check("t6_pend", pend, 1);
        do_reset();
        ready_mode = 0;
        push_pkt(3, 1'b0, 1'b1);
        drain_all(40);
        check("t6_cnt0", pkt_cnt0, 1);
        check("t6_cnt1", pkt_cnt1, 0);

        // Randomised traffic, random back-pressure and upstream starvation
        ready_mode = 2;
        starve_pct = 30;
        for (int p = 0; p < 30; p++)
            push_pkt($urandom_range(1, 4), 1'($urandom), 1'b0);
        drain_all(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pkt_fork
